// File: rtl/video_stream_sink_if.sv
// Avalon-ST pixel stream bundle: source drives beats, sink drives ready.
interface video_stream_sink_if #(
    parameter int DATA_W = 8
);
    logic              sink_valid;
    logic              sink_ready;
    logic              sink_startofpacket;
    logic              sink_endofpacket;
    logic [DATA_W-1:0] sink_data;

    modport master (
        output sink_valid,
        output sink_startofpacket,
        output sink_endofpacket,
        output sink_data,
        input  sink_ready
    );

    modport slave (
        input  sink_valid,
        input  sink_startofpacket,
        input  sink_endofpacket,
        input  sink_data,
        output sink_ready
    );
endinterface

// File: rtl/video_stream_sink.sv
// Avalon-ST video sink: framing check, frame-buffer writes, frame counting.
// Optional per-frame CRC-16-CCITT when VIDEO_STREAM_SINK_CRC_EN is defined.
module video_stream_sink #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
) (
    input  logic              clock,
    input  logic              reset,
    video_stream_sink_if.slave sink,
    input  logic              fb_busy,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              err_sop,
    output logic              err_eop,
    input  logic              err_clear,
    output logic [15:0]       frame_crc
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
    localparam bit SINGLE = (NPIX == 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic [15:0]       fcnt_q;
    logic              esop_q, eeop_q;

    logic              acc;
    logic              sop, eop;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic              set_sop, set_eop;
    logic              good;

    assign sink.sink_ready = reset & ~fb_busy;
    assign acc = sink.sink_valid & sink.sink_ready;
    assign sop = sink.sink_startofpacket;
    assign eop = sink.sink_endofpacket;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr      = 1'b0;
        wr_addr = cnt_q;
        set_sop = 1'b0;
        set_eop = 1'b0;
        good    = 1'b0;
        if (acc) begin
            if (sop) begin
                // A SOP always restarts the frame, whatever state we are in
                set_sop = (state_q != S_IDLE);
                wr      = 1'b1;
                wr_addr = '0;
                if (eop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (SINGLE) good = 1'b1;
                    else        set_eop = 1'b1;
                end else if (SINGLE) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    set_eop = 1'b1;
                end else begin
                    state_d = S_ACTIVE;
                    cnt_d   = ADDR_W'(1);
                end
            end else begin
                case (state_q)
                    S_IDLE: set_sop = 1'b1;
                    S_ACTIVE: begin
                        wr = 1'b1;
                        if (eop) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            if (cnt_q == LAST) good = 1'b1;
                            else               set_eop = 1'b1;
                        end else if (cnt_q == LAST) begin
                            state_d = S_DRAIN;
                            cnt_d   = '0;
                            set_eop = 1'b1;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                    S_DRAIN: if (eop) state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            esop_q  <= 1'b0;
            eeop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= wr;
            done_q  <= good;
            if (wr) begin
                addr_q  <= wr_addr;
                wdata_q <= sink.sink_data;
            end
            if (good) fcnt_q <= fcnt_q + 16'd1;
            esop_q <= set_sop | (esop_q & ~err_clear);
            eeop_q <= set_eop | (eeop_q & ~err_clear);
        end
    end

    assign fb_we       = we_q;
    assign fb_addr     = addr_q;
    assign fb_wdata    = wdata_q;
    assign frame_done  = done_q;
    assign frame_count = fcnt_q;
    assign err_sop     = esop_q;
    assign err_eop     = eeop_q;

`ifdef VIDEO_STREAM_SINK_CRC_EN
    function automatic logic [15:0] crc_step(
        input logic [15:0]       c,
        input logic [DATA_W-1:0] d
    );
        logic [15:0] r;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    logic [15:0] crc_q, crc_base, crc_next, fcrc_q;

    assign crc_base = (acc & sop) ? 16'hFFFF : crc_q;
    assign crc_next = crc_step(crc_base, sink.sink_data);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc_q  <= 16'hFFFF;
            fcrc_q <= '0;
        end else begin
            if (wr)   crc_q  <= crc_next;
            if (good) fcrc_q <= crc_next;
        end
    end

    assign frame_crc = fcrc_q;
`else
    assign frame_crc = '0;
`endif
endmodule

// File: tb/tb_video_stream_sink.sv
// Bench for video_stream_sink: frame-level model checked every cycle,
// plus directed literal checks on a 4x2 and a 1x1 instance.
module tb_video_stream_sink;
    localparam int N  = 8;
    localparam int AW = 19;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    video_stream_sink_if #(.DATA_W(8)) s0 ();
    video_stream_sink_if #(.DATA_W(8)) s1 ();

    logic          fb_busy = 1'b0;
    logic          err_clear = 1'b0;
    logic          fb_we, frame_done, err_sop, err_eop;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wdata;
    logic [15:0]   frame_count, frame_crc;

    logic          busy1 = 1'b0;
    logic          clr1 = 1'b0;
    logic          we1, done1, esop1, eeop1;
    logic [AW-1:0] addr1;
    logic [7:0]    wdata1;
    logic [15:0]   cnt1, crc1;

    video_stream_sink #(.WIDTH(4), .HEIGHT(2), .DATA_W(8), .ADDR_W(AW)) u0 (
        .clock(clock), .reset(reset), .sink(s0.slave),
        .fb_busy(fb_busy), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .frame_done(frame_done),
        .frame_count(frame_count), .err_sop(err_sop), .err_eop(err_eop),
        .err_clear(err_clear), .frame_crc(frame_crc)
    );

    video_stream_sink #(.WIDTH(1), .HEIGHT(1), .DATA_W(8), .ADDR_W(AW)) u1 (
        .clock(clock), .reset(reset), .sink(s1.slave),
        .fb_busy(busy1), .fb_we(we1), .fb_addr(addr1),
        .fb_wdata(wdata1), .frame_done(done1),
        .frame_count(cnt1), .err_sop(esop1), .err_eop(eeop1),
        .err_clear(clr1), .frame_crc(crc1)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[k]) begin
            c = c ^ {q[k], 8'h00};
            repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // model: pos = -1 outside a frame, 0..N-1 next pixel, N = draining
    int         pos = -1;
    logic [7:0] fpx[$];
    logic       e_we = 0, e_done = 0, e_es = 0, e_ee = 0;
    int         e_addr = 0;
    logic [7:0] e_wdata = 0;
    logic [15:0] e_cnt = 0, e_crc = 0;

    int         log_a[$];
    logic [7:0] log_d[$];
    int         n_done = 0;

    task automatic model_good();
        e_done = 1;
        e_cnt  = e_cnt + 16'd1;
`ifdef VIDEO_STREAM_SINK_CRC_EN
        e_crc = crc_ref(fpx);
`endif
    endtask

    initial forever begin
        logic acc, ss, se, d_sop, d_eop;
        logic [7:0] d;
        @(negedge clock);
        if (!reset) begin
            pos = -1; fpx.delete();
            e_we = 0; e_done = 0; e_es = 0; e_ee = 0;
            e_cnt = 0; e_crc = 0;
        end
        chk("sink_ready", s0.sink_ready, reset & ~fb_busy);
        chk("fb_we", fb_we, e_we);
        if (e_we) begin
            chk("fb_addr", fb_addr, e_addr);
            chk("fb_wdata", fb_wdata, e_wdata);
        end
        chk("frame_done", frame_done, e_done);
        chk("frame_count", frame_count, e_cnt);
        chk("err_sop", err_sop, e_es);
        chk("err_eop", err_eop, e_ee);
        chk("frame_crc", frame_crc, e_crc);
        if (fb_we) begin
            log_a.push_back(int'(fb_addr));
            log_d.push_back(fb_wdata);
        end
        if (frame_done) n_done++;
        if (reset) begin
            acc = s0.sink_valid & ~fb_busy;
            d = s0.sink_data;
            d_sop = s0.sink_startofpacket;
            d_eop = s0.sink_endofpacket;
            ss = 0; se = 0; e_we = 0; e_done = 0;
            if (acc) begin
                if (d_sop) begin
                    ss = (pos != -1);
                    fpx.delete(); fpx.push_back(d);
                    e_we = 1; e_addr = 0; e_wdata = d;
                    if (d_eop) begin
                        pos = -1;
                        if (N == 1) model_good(); else se = 1;
                    end else if (N == 1) begin
                        pos = N; se = 1;
                    end else pos = 1;
                end else if (pos == -1) begin
                    ss = 1;
                end else if (pos == N) begin
                    if (d_eop) pos = -1;
                end else begin
                    fpx.push_back(d);
                    e_we = 1; e_addr = pos; e_wdata = d;
                    if (d_eop) begin
                        if (pos == N - 1) model_good(); else se = 1;
                        pos = -1;
                    end else if (pos == N - 1) begin
                        se = 1; pos = N;
                    end else pos++;
                end
            end
            e_es = ss | (e_es & ~err_clear);
            e_ee = se | (e_ee & ~err_clear);
        end
    end

    bit toggle_busy = 0;

    task automatic cyc();
        @(posedge clock);
        #2;
        if (toggle_busy) fb_busy = ~fb_busy;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic beat(input logic [7:0] d, input bit sop, input bit eop);
        bit done;
        done = 0;
        s0.sink_valid = 1;
        s0.sink_data = d;
        s0.sink_startofpacket = sop;
        s0.sink_endofpacket = eop;
        for (int k = 0; k < 50 && !done; k++) begin
            done = !fb_busy;
            cyc();
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_timeout: got no accept expected accept");
        end
        s0.sink_valid = 0;
        s0.sink_startofpacket = 0;
        s0.sink_endofpacket = 0;
    endtask

    task automatic good_frame(input logic [7:0] base);
        for (int i = 0; i < N; i++)
            beat(base + 8'(i), i == 0, i == N - 1);
    endtask

    task automatic log_clear();
        log_a.delete(); log_d.delete(); n_done = 0;
    endtask

    task automatic pulse_clear();
        err_clear = 1; cyc(); err_clear = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        cyc();
        chk("rst_ready", s0.sink_ready, 0);
        chk("rst_we", fb_we, 0);
        cyc();
        reset = 1;
        cyc();
    endtask

    initial begin
        logic [7:0] q0[$];
        s0.sink_valid = 0; s0.sink_data = 0;
        s0.sink_startofpacket = 0; s0.sink_endofpacket = 0;
        s1.sink_valid = 0; s1.sink_data = 0;
        s1.sink_startofpacket = 0; s1.sink_endofpacket = 0;
        idle(2);
        chk("rst_ready0", s0.sink_ready, 0);
        chk("rst_count0", frame_count, 0);
        chk("rst_err0", {err_sop, err_eop}, 0);
        reset = 1;
        cyc();

        log_clear();
        good_frame(8'h10);
        idle(3);
        chk("t1_nwr", log_a.size(), 8);
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            chk("t1_addr", log_a[i], i);
            chk("t1_data", log_d[i], 8'h10 + 8'(i));
        end
        chk("t1_done", n_done, 1);
        chk("t1_count", frame_count, 1);
        chk("t1_err", {err_sop, err_eop}, 0);

        log_clear();
        toggle_busy = 1;
        good_frame(8'h10);
        idle(3);
        toggle_busy = 0; fb_busy = 0;
        chk("t2_nwr", log_a.size(), 8);
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            chk("t2_addr", log_a[i], i);
            chk("t2_data", log_d[i], 8'h10 + 8'(i));
        end
        chk("t2_count", frame_count, 2);

        do_reset();
        log_clear();
        for (int i = 0; i < 6; i++) beat(8'h30 + 8'(i), i == 0, i == 5);
        idle(2);
        chk("t3_nwr", log_a.size(), 6);
        if (log_a.size() == 6) chk("t3_last", log_a[5], 5);
        chk("t3_err_eop", err_eop, 1);
        chk("t3_count", frame_count, 0);
        good_frame(8'h40);
        idle(2);
        chk("t3_count2", frame_count, 1);
        pulse_clear();
        cyc();
        chk("t3_clear", err_eop, 0);

        log_clear();
        for (int i = 0; i < 3; i++) beat(8'h50 + 8'(i), 0, 0);
        idle(2);
        chk("t4_nwr", log_a.size(), 0);
        chk("t4_err_sop", err_sop, 1);
        pulse_clear();
        beat(8'h60, 1, 0); beat(8'h61, 0, 0); beat(8'h62, 0, 0);
        beat(8'h63, 1, 0);
        for (int i = 1; i < N; i++) beat(8'h63 + 8'(i), 0, i == N - 1);
        idle(2);
        chk("t4_nwr2", log_a.size(), 11);
        if (log_a.size() == 11) begin
            chk("t4_rs_addr", log_a[3], 0);
            chk("t4_rs_data", log_d[3], 8'h63);
            chk("t4_end_addr", log_a[10], 7);
        end
        chk("t4_err_sop2", err_sop, 1);
        chk("t4_count", frame_count, 2);
        pulse_clear();
        err_clear = 1;
        beat(8'h70, 0, 0);
        err_clear = 0;
        cyc();
        chk("t4_set_wins", err_sop, 1);

        pulse_clear();
        log_clear();
        for (int i = 0; i < 8; i++) beat(8'h80 + 8'(i), i == 0, 0);
        beat(8'h88, 0, 0); beat(8'h89, 0, 1);
        idle(2);
        chk("t5_nwr", log_a.size(), 8);
        chk("t5_err", {err_sop, err_eop}, 2'b01);
        chk("t5_count", frame_count, 2);
        good_frame(8'h90);
        idle(2);
        chk("t5_count2", frame_count, 3);
        chk("t5_nwr2", log_a.size(), 16);
        if (log_a.size() == 16) begin
            chk("t5_addr", log_a[8], 0);
            chk("t5_data", log_d[8], 8'h90);
        end

        log_clear();
        for (int i = 0; i < 3; i++) beat(8'hA0 + 8'(i), i == 0, 0);
        do_reset();
        idle(2);
        chk("t6_count", frame_count, 0);
        chk("t6_done", n_done, 0);

        q0.push_back(8'h00);
        chk("crc_ref_pin", crc_ref(q0), 16'hE1F0);
        s1.sink_valid = 1; s1.sink_data = 8'h00;
        s1.sink_startofpacket = 1; s1.sink_endofpacket = 1;
        cyc();
        s1.sink_valid = 0;
        s1.sink_startofpacket = 0; s1.sink_endofpacket = 0;
        chk("t7_we", we1, 1);
        chk("t7_addr", addr1, 0);
        chk("t7_done", done1, 1);
        chk("t7_count", cnt1, 1);
        chk("t7_err", {esop1, eeop1}, 0);
`ifdef VIDEO_STREAM_SINK_CRC_EN
        chk("t7_crc", crc1, crc_ref(q0));
`else
        chk("t7_crc", crc1, 0);
`endif
        cyc();
        chk("t7_we_off", we1, 0);
        chk("t7_done_off", done1, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
